// File: rtl/fib_pkg.sv
// Shared widths, FSM encoding and 7-segment patterns for the Fibonacci BCD display.
package fib_pkg;

  localparam int unsigned BIN_W      = 16;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned ITER_W     = $clog2(BIN_W);
  localparam int unsigned IDX_W      = $clog2(BCD_DIGITS);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Active-high {g,f,e,d,c,b,a} patterns.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/fib_bcd_display_if.sv
// Load/result/display bundle between the Fibonacci datapath side and the BCD display block.
interface fib_bcd_display_if;

  logic                            load;
  logic [fib_pkg::BIN_W-1:0]       bin_in;
  logic                            busy;
  logic                            done;
  logic                            valid;
  logic [fib_pkg::BCD_W-1:0]       bcd_out;
  logic [fib_pkg::SEG_W-1:0]       seg;
  logic [fib_pkg::BCD_DIGITS-1:0]  an;

  modport master (
    output load, bin_in,
    input  busy, done, valid, bcd_out, seg, an
  );

  modport slave (
    input  load, bin_in,
    output busy, done, valid, bcd_out, seg, an
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-high 7-segment decoder; codes 10-15 decode to blank.
module bcd_to_7seg
  import fib_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (digit)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fib_bcd_display.sv
// Captures a 16-bit result, converts it to BCD by sequential double-dabble and
// scans the buffered digits onto a multiplexed 5-digit 7-segment display.
module fib_bcd_display
  import fib_pkg::*;
#(
  parameter int unsigned REFRESH_BITS   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
)(
  input logic               clk,
  input logic               reset,
  fib_bcd_display_if.slave  bus
);

  state_t                   state;
  logic [BIN_W-1:0]         shift_q;
  logic [BCD_W-1:0]         scratch_q;
  logic [ITER_W-1:0]        iter_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     valid_q;
  logic [BCD_W-1:0]         bcd_q;
  logic [REFRESH_BITS-1:0]  refresh_q;
  logic [IDX_W-1:0]         idx_q;
  logic [SEG_W-1:0]         seg_q;
  logic [BCD_DIGITS-1:0]    an_q;

  logic [BCD_W-1:0]         adj_c;
  logic [BCD_W-1:0]         scratch_nx_c;
  logic [BIN_W-1:0]         shift_nx_c;
  logic [3:0]               digit_c;
  logic [BCD_DIGITS-1:0]    lead_c;
  logic                     shown_c;
  logic [SEG_W-1:0]         dec_c;
  logic [SEG_W-1:0]         seg_nx_c;
  logic [BCD_DIGITS-1:0]    an_nx_c;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
  always_comb begin
    adj_c = scratch_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    {scratch_nx_c, shift_nx_c} = {adj_c, shift_q} << 1;
  end

  // Selected digit and leading-zero mask; lead_c[i] means some digit >= i is nonzero.
  always_comb begin
    digit_c = '0;
    lead_c  = '0;
    for (int i = int'(BCD_DIGITS) - 1; i >= 0; i--) begin
      if (idx_q == IDX_W'(i)) digit_c = bcd_q[4*i +: 4];
      if (i == int'(BCD_DIGITS) - 1) lead_c[i] = |bcd_q[4*i +: 4];
      else                           lead_c[i] = lead_c[i+1] | (|bcd_q[4*i +: 4]);
    end
    lead_c[0] = 1'b1;
    shown_c   = valid_q & lead_c[idx_q];
  end

  bcd_to_7seg u_dec (
    .digit (digit_c),
    .seg_c (dec_c)
  );

  always_comb begin
    seg_nx_c = shown_c ? dec_c : SEG_BLANK;
    an_nx_c  = BCD_DIGITS'(1) << idx_q;
    if (SEG_ACTIVE_LOW) begin
      seg_nx_c = ~seg_nx_c;
      an_nx_c  = ~an_nx_c;
    end
  end

  // Conversion FSM and result buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            shift_q   <= bus.bin_in;
            scratch_q <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_nx_c;
          shift_q   <= shift_nx_c;
          iter_q    <= iter_q + ITER_W'(1);
          if (iter_q == ITER_W'(BIN_W - 1)) begin
            bcd_q   <= scratch_nx_c;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh scan; seg/an register the digit selected by the current index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
      an_q      <= SEG_ACTIVE_LOW ? ~BCD_DIGITS'(1) : BCD_DIGITS'(1);
    end else begin
      refresh_q <= refresh_q + REFRESH_BITS'(1);
      if (&refresh_q) idx_q <= (idx_q == IDX_W'(BCD_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      seg_q <= seg_nx_c;
      an_q  <= an_nx_c;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.valid   = valid_q;
  assign bus.bcd_out = bcd_q;
  assign bus.seg     = seg_q;
  assign bus.an      = an_q;

endmodule

// File: tb/tb_fib_bcd_display.sv
// Directed bench for fib_bcd_display: scoreboarded conversions plus display scan checks.
module tb_fib_bcd_display;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fib_bcd_display_if bus ();

  fib_bcd_display #(.REFRESH_BITS(2), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] model_bcd = '0;
  logic        model_valid = 1'b0;

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_tab(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected active-low segment pins for digit position idx.
  function automatic logic [6:0] exp_seg(input int idx);
    logic [19:0] t;
    logic        shown;
    t     = model_bcd >> (4 * idx);
    shown = model_valid && (idx == 0 || t != 20'd0);
    return shown ? ~seg_tab(t[3:0]) : 7'h7F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load val and wait for done; optionally re-assert load at sample cnt==inject_at.
  task automatic convert(input logic [15:0] val, input int inject_at, input logic [15:0] inject_val);
    int          cnt = 0;
    int          busy_cycles = 0;
    bit          got = 0;
    logic [19:0] exp;
    exp_q.push_back(to_bcd(int'(val)));
    bus.load   = 1'b1;
    bus.bin_in = val;
    @(negedge clk);
    bus.load   = 1'b0;
    bus.bin_in = 16'($urandom);
    if (bus.busy) busy_cycles++;
    while (!got && cnt < 40) begin
      if (cnt == inject_at) begin
        bus.load   = 1'b1;
        bus.bin_in = inject_val;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
      cnt++;
      if (bus.done) got = 1;
      else if (bus.busy) busy_cycles++;
    end
    bus.load = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(cnt), 32'd16);
    check("busy_cycles", 32'(busy_cycles), 32'd16);
    exp = exp_q.pop_front();
    check("bcd_out", 32'(bus.bcd_out), 32'(exp));
    check("valid", 32'(bus.valid), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    model_bcd   = exp;
    model_valid = 1'b1;
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
  endtask

  // Watch the scan; on every digit change check segments, ordering and dwell time.
  task automatic scan(input int cycles);
    logic [4:0] prev = bus.an;
    int dwell = 0;
    int idx;
    int prev_idx = 0;
    int transitions = 0;
    repeat (cycles) begin
      @(negedge clk);
      dwell++;
      if (bus.an != prev) begin
        idx = -1;
        for (int i = 0; i < 5; i++) if (~bus.an == (5'd1 << i)) idx = i;
        check("an_onehot", 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
          check($sformatf("seg_d%0d", idx), 32'(bus.seg), 32'(exp_seg(idx)));
          if (transitions > 0) begin
            check("dwell", 32'(dwell), 32'd4);
            check("an_order", 32'(idx), 32'((prev_idx + 1) % 5));
          end
          prev_idx = idx;
        end
        transitions++;
        prev  = bus.an;
        dwell = 0;
      end
    end
    check("scan_transitions", 32'(transitions >= 5), 32'd1);
  endtask

  initial begin
    reset      = 1'b0;
    bus.load   = 1'b0;
    bus.bin_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(bus.busy),    32'd0);
    check("rst_done",  32'(bus.done),    32'd0);
    check("rst_valid", 32'(bus.valid),   32'd0);
    check("rst_bcd",   32'(bus.bcd_out), 32'd0);
    check("rst_an",    32'(bus.an),      32'h1E);
    check("rst_seg",   32'(bus.seg),     32'h7F);
    reset = 1'b1;
    scan(24);

    convert(16'd0, -1, 16'd0);
    scan(24);
    convert(16'd46368, -1, 16'd0);
    scan(24);
    convert(16'd65535, -1, 16'd0);
    convert(16'd89, -1, 16'd0);
    scan(24);

    // Load while busy, and load on the done edge, must both be ignored.
    convert(16'd1597, 4, 16'd9999);
    convert(16'd610, 15, 16'd4321);

    // Abort mid-conversion.
    bus.load   = 1'b1;
    bus.bin_in = 16'd1234;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy",  32'(bus.busy),    32'd0);
    check("abort_valid", 32'(bus.valid),   32'd0);
    check("abort_bcd",   32'(bus.bcd_out), 32'd0);
    check("abort_done",  32'(bus.done),    32'd0);
    check("abort_seg",   32'(bus.seg),     32'h7F);
    check("abort_an",    32'(bus.an),      32'h1E);
    model_bcd   = '0;
    model_valid = 1'b0;
    reset = 1'b1;
    convert(16'd1234, -1, 16'd0);
    scan(24);

    repeat (3) convert(16'($urandom), -1, 16'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
